approx_pixel_diff: RTL

Streaming approximate pixel subtractor, the inverse-direction companion of the approximate 8-bit pixel adder in the spintronic image-processing datapath. It accepts 8-bit pixel pairs over a valid/ready handshake and computes a signed difference. The low bits use the same carry-free approximation style as the adder, so the two units trade accuracy for energy in matching ways. It also produces the absolute difference and a per-block sum of absolute differences (SAD) for motion and edge metrics, through a 2-stage pipeline with backpressure.

---
 rtl/approx_pixel_diff.sv | 98 +++++++++
 1 files changed

// File: rtl/approx_pixel_diff.sv
// Streaming approximate pixel subtractor: borrow-free low bits, absolute difference
// and per-block SAD through a 2-stage valid/ready pipeline with backpressure.
module approx_pixel_diff #(
    parameter int APPROX_BITS = 2,
    parameter int BLOCK_LEN   = 16,
    parameter int SAD_W       = 8 + $clog2(BLOCK_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_diff,
    output logic [7:0]       out_abs,
    output logic             out_last,
    output logic [SAD_W-1:0] out_sad
);

    localparam int               CNT_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLOCK_LEN - 1);
    localparam logic [8:0]       LOW_MASK = 9'((1 << APPROX_BITS) - 1);

    logic             adv;
    logic [8:0]       a_hi;
    logic [8:0]       b_hi;
    logic [8:0]       hi_diff;
    logic [8:0]       new_diff;

    logic [CNT_W-1:0] pair_cnt;
    logic             s1_valid;
    logic [8:0]       s1_diff;
    logic             s1_last;
    logic [8:0]       s1_neg;
    logic [7:0]       s1_abs;
    logic             first_beat;

    // Both stages move together; a bubble in S2 lets the whole pipe advance.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // The upper bits subtract with borrow-in 0; the low bits are a carry-free XOR,
    // so the borrow out of the low field is simply never generated.
    always_comb begin
        a_hi     = {1'b0, a} >> APPROX_BITS;
        b_hi     = {1'b0, b} >> APPROX_BITS;
        hi_diff  = a_hi - b_hi;
        new_diff = (hi_diff << APPROX_BITS) | ({1'b0, a ^ b} & LOW_MASK);
    end

    // The most negative difference is -255, so negation always fits in 8 bits.
    always_comb begin
        s1_neg = 9'd0 - s1_diff;
        s1_abs = s1_diff[8] ? s1_neg[7:0] : s1_diff[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_cnt <= '0;
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_last  <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_diff  <= new_diff;
                s1_last  <= (pair_cnt == CNT_MAX);
                pair_cnt <= (pair_cnt == CNT_MAX) ? '0 : pair_cnt + 1'b1;
            end
        end
    end

    // out_sad doubles as the accumulator, so it always includes the beat on display.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_diff   <= '0;
            out_abs    <= '0;
            out_last   <= 1'b0;
            out_sad    <= '0;
            first_beat <= 1'b1;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_diff   <= s1_diff;
                out_abs    <= s1_abs;
                out_last   <= s1_last;
                out_sad    <= first_beat ? SAD_W'(s1_abs) : out_sad + SAD_W'(s1_abs);
                first_beat <= s1_last;
            end
        end
    end

endmodule
